// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: turns each 6502 bus cycle (clkPhi0 sampled as data) into a
// single PSRAM controller request, all on the clkRAM clock. RDY is held low
// while an access is outstanding; a stuck controller is aborted after
// TIMEOUT_CYCLES and flagged on a sticky o_timeout.
// Optional build macro CPU_READ_CACHE_EN: one-entry read cache keyed on
// {bank, addr}, so repeated reads of the same location skip the controller.
module cpu_mem_bridge #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] TIMEOUT_DATA   = 8'hFF,
  parameter int         CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clkPhi0,
  input  logic [15:0] i_cpuAddr,
  input  logic        i_cpuWE,
  input  logic [7:0]  i_cpuDO,
  input  logic [5:0]  i_bank,
  output logic [7:0]  o_cpuDI,
  output logic        o_rdy,
  output logic        o_cs,
  output logic        o_write,
  output logic [5:0]  o_bank,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dataToWrite,
  input  logic        i_busy,
  input  logic        i_dataReady,
  input  logic [7:0]  i_dataRead,
  output logic        o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic               phi0_reg;
  logic [7:0]         cpu_di_reg, cpu_di_next;
  logic               rdy_reg, rdy_next;
  logic               cs_reg, cs_next;
  logic               write_reg, write_next;
  logic [5:0]         bank_reg, bank_next;
  logic [15:0]        addr_reg, addr_next;
  logic [7:0]         wdata_reg, wdata_next;
  logic               timeout_reg, timeout_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic cycle_start;
  logic access_done;
  logic timeout_hit;

  // A CPU cycle begins on the rising edge of the sampled phase clock.
  assign cycle_start = i_clkPhi0 & ~phi0_reg;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  // A read may complete while still issuing if busy and data arrive together.
  assign access_done = ((state_reg == S_ISSUE) & i_busy & ~write_reg & i_dataReady) |
                       ((state_reg == S_WAIT) & (write_reg ? ~i_busy : i_dataReady));

`ifdef CPU_READ_CACHE_EN
  logic        tag_valid_reg, tag_valid_next;
  logic [21:0] tag_reg, tag_next;
  logic        tag_match;
  // o_cpuDI always holds the data for the tagged location while valid.
  assign tag_match = tag_valid_reg & (tag_reg == {i_bank, i_cpuAddr});
`endif

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_next   = state_reg;
    cpu_di_next  = cpu_di_reg;
    rdy_next     = rdy_reg;
    cs_next      = cs_reg;
    write_next   = write_reg;
    bank_next    = bank_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    timeout_next = timeout_reg;
    cnt_next     = cnt_reg;
`ifdef CPU_READ_CACHE_EN
    tag_valid_next = tag_valid_reg;
    tag_next       = tag_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (cycle_start) begin
          addr_next  = i_cpuAddr;
          write_next = i_cpuWE;
          wdata_next = i_cpuDO;
          bank_next  = i_bank;
          cnt_next   = '0;
          rdy_next   = 1'b0;
`ifdef CPU_READ_CACHE_EN
          if (tag_match & ~i_cpuWE) begin
            state_next = S_DONE;
          end else begin
            cs_next    = 1'b1;
            state_next = S_ISSUE;
            if (tag_match) cpu_di_next = i_cpuDO;
          end
`else
          cs_next    = 1'b1;
          state_next = S_ISSUE;
`endif
        end
      end
      S_ISSUE, S_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (access_done) begin
          cs_next    = 1'b0;
          rdy_next   = 1'b1;
          state_next = S_DONE;
          if (~write_reg) begin
            cpu_di_next = i_dataRead;
`ifdef CPU_READ_CACHE_EN
            tag_valid_next = 1'b1;
            tag_next       = {bank_reg, addr_reg};
`endif
          end
        end else if (timeout_hit) begin
          cs_next      = 1'b0;
          rdy_next     = 1'b1;
          timeout_next = 1'b1;
          state_next   = S_DONE;
          if (~write_reg) cpu_di_next = TIMEOUT_DATA;
`ifdef CPU_READ_CACHE_EN
          tag_valid_next = 1'b0;
`endif
        end else if ((state_reg == S_ISSUE) && i_busy) begin
          cs_next    = 1'b0;
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        rdy_next   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      phi0_reg    <= 1'b0;
      cpu_di_reg  <= 8'h00;
      rdy_reg     <= 1'b1;
      cs_reg      <= 1'b0;
      write_reg   <= 1'b0;
      bank_reg    <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      timeout_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      phi0_reg    <= i_clkPhi0;
      cpu_di_reg  <= cpu_di_next;
      rdy_reg     <= rdy_next;
      cs_reg      <= cs_next;
      write_reg   <= write_next;
      bank_reg    <= bank_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
    end
  end

`ifdef CPU_READ_CACHE_EN
  // Cache tag register; reset only needs to drop the valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_reg <= 1'b0;
      tag_reg       <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_reg       <= tag_next;
    end
  end
`endif

  assign o_cpuDI       = cpu_di_reg;
  assign o_rdy         = rdy_reg;
  assign o_cs          = cs_reg;
  assign o_write       = write_reg;
  assign o_bank        = bank_reg;
  assign o_addr        = addr_reg;
  assign o_dataToWrite = wdata_reg;
  assign o_timeout     = timeout_reg;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Testbench for cpu_mem_bridge: table-driven transactions, hand-written
// timeout / reset / dropped-edge / cache sequences, then randomized accesses
// checked against a behavioural model of the CPU-visible read data.
module tb_cpu_mem_bridge;

  localparam int TO = 1024;
`ifdef CPU_READ_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_clkPhi0 = 1'b0;
  logic [15:0] i_cpuAddr = '0;
  logic        i_cpuWE = 1'b0;
  logic [7:0]  i_cpuDO = '0;
  logic [5:0]  i_bank = '0;
  logic        i_busy = 1'b0;
  logic        i_dataReady = 1'b0;
  logic [7:0]  i_dataRead = '0;
  logic [7:0]  o_cpuDI;
  logic        o_rdy, o_cs, o_write, o_timeout;
  logic [5:0]  o_bank;
  logic [15:0] o_addr;
  logic [7:0]  o_dataToWrite;

  cpu_mem_bridge #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(8'hFF), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .i_clkPhi0(i_clkPhi0), .i_cpuAddr(i_cpuAddr),
    .i_cpuWE(i_cpuWE), .i_cpuDO(i_cpuDO), .i_bank(i_bank), .o_cpuDI(o_cpuDI),
    .o_rdy(o_rdy), .o_cs(o_cs), .o_write(o_write), .o_bank(o_bank), .o_addr(o_addr),
    .o_dataToWrite(o_dataToWrite), .i_busy(i_busy), .i_dataReady(i_dataReady),
    .i_dataRead(i_dataRead), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Reference model: what the CPU should see on DI, plus the cache tag.
  logic [7:0]  m_di = 8'h00;
  logic        m_valid = 1'b0;
  logic [21:0] m_tag = '0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [5:0]  bank;
    logic [7:0]  wdata;
    int          busy_dly;
    int          rdy_dly;
    logic [7:0]  rdata;
    bit          drop;
    logic [7:0]  exp_di;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic we, input logic [5:0] bank, input logic [15:0] addr);
    return CACHE_EN && !we && m_valid && (m_tag == {bank, addr});
  endfunction

  function automatic logic [7:0] predict(input logic we, input logic [5:0] bank,
                                         input logic [15:0] addr, input logic [7:0] wdata,
                                         input logic [7:0] rdata);
    if (!we) return model_hit(we, bank, addr) ? m_di : rdata;
    if (CACHE_EN && m_valid && (m_tag == {bank, addr})) return wdata;
    return m_di;
  endfunction

  task automatic check_reset_state(input string name);
    chk({name, "_ctl"}, {14'h0, o_cpuDI, o_rdy, o_cs, o_write, o_timeout, o_bank},
        {14'h0, 8'h00, 4'b1000, 6'h00});
    chk({name, "_addr"}, {16'h0, o_addr}, 32'h0);
    chk({name, "_wdata"}, {24'h0, o_dataToWrite}, 32'h0);
  endtask

  // One CPU bus cycle, with the bench acting as the memory controller.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [5:0] bank,
                     input logic [7:0] wdata, input int busy_dly, input int rdy_dly,
                     input logic [7:0] rdata, input bit drop, input logic [7:0] exp_di);
    bit   hit;
    int   n;
    int   cs_rises;
    int   rdy_early;
    logic cs_prev;
    string t;
    t = $sformatf("txn%0d", txn_no);
    hit = model_hit(we, bank, addr);
    n = busy_dly + rdy_dly;
    @(negedge clk);
    cs_prev = o_cs;
    i_cpuAddr = addr; i_cpuWE = we; i_cpuDO = wdata; i_bank = bank; i_clkPhi0 = 1'b1;
    @(negedge clk);
    i_clkPhi0 = 1'b0;
    if (hit) begin
      chk({t, "_hit_cs"}, {31'h0, o_cs}, 32'h0);
      chk({t, "_hit_rdy_low"}, {31'h0, o_rdy}, 32'h0);
      @(negedge clk);
      chk({t, "_hit_rdy"}, {31'h0, o_rdy}, 32'h1);
      chk({t, "_hit_di"}, {24'h0, o_cpuDI}, {24'h0, exp_di});
    end else begin
      cs_rises = 0;
      rdy_early = 0;
      for (int cyc = 0; cyc <= n + 1; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (o_cs && !cs_prev) cs_rises++;
        cs_prev = o_cs;
        if (cyc <= n && o_rdy) rdy_early++;
        if (cyc == n + 1) break;
        if (we) i_busy = (cyc >= busy_dly) && (cyc < n);
        else    i_busy = (cyc >= busy_dly) && (cyc <= n);
        i_dataReady = !we && (cyc == n);
        i_dataRead  = (cyc == n) ? rdata : 8'hEE;
        if (drop && cyc == 1) begin
          i_cpuAddr = addr ^ 16'h0F0F; i_cpuWE = ~we; i_clkPhi0 = 1'b1;
        end
        if (drop && cyc == 2) i_clkPhi0 = 1'b0;
      end
      i_busy = 1'b0; i_dataReady = 1'b0;
      chk({t, "_cs_count"}, cs_rises, 1);
      chk({t, "_rdy_low"}, rdy_early, 0);
      chk({t, "_rdy"}, {31'h0, o_rdy}, 32'h1);
      chk({t, "_cs_off"}, {31'h0, o_cs}, 32'h0);
      chk({t, "_di"}, {24'h0, o_cpuDI}, {24'h0, exp_di});
      chk({t, "_bus"}, {o_write, o_bank, o_addr, 1'b0, o_dataToWrite},
          {we, bank, addr, 1'b0, wdata});
    end
    $display("txn %0d: we=%0b bank=%0d addr=%h wdata=%h rdata=%h hit=%0b drop=%0b di=%h exp=%h",
             txn_no, we, bank, addr, wdata, rdata, hit, drop, o_cpuDI, exp_di);
    if (!hit) begin
      if (!we) begin
        m_di = rdata; m_valid = 1'b1; m_tag = {bank, addr};
      end else if (CACHE_EN && m_valid && (m_tag == {bank, addr})) begin
        m_di = wdata;
      end
    end
    txn_no++;
  endtask

  initial begin
    logic [15:0] addr_pool[4];
    int stall_bad;
    logic we_r;
    logic [15:0] a_r;
    logic [5:0] b_r;
    logic [7:0] w_r, r_r;
    int bd, rd;
    bit dr;

    addr_pool[0] = 16'hC000; addr_pool[1] = 16'hC001;
    addr_pool[2] = 16'hD020; addr_pool[3] = 16'h1234;

    vecs[0] = '{1'b0, 16'hC000, 6'd0,  8'h00, 2, 3, 8'h79, 1'b0, 8'h79};
    vecs[1] = '{1'b1, 16'hD020, 6'd1,  8'h05, 1, 2, 8'h00, 1'b0, 8'h79};
    vecs[2] = '{1'b0, 16'h1234, 6'd3,  8'h00, 0, 0, 8'hA5, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 16'h0000, 6'd63, 8'h00, 1, 3, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 16'hFFFF, 6'd2,  8'h3C, 0, 1, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 16'hFFFF, 6'd2,  8'h00, 3, 4, 8'h3C, 1'b1, 8'h3C};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 6; i++)
      txn(vecs[i].we, vecs[i].addr, vecs[i].bank, vecs[i].wdata, vecs[i].busy_dly,
          vecs[i].rdy_dly, vecs[i].rdata, vecs[i].drop, vecs[i].exp_di);

    // Timeout: the controller never answers.
    @(negedge clk);
    i_cpuAddr = 16'hBEEF; i_cpuWE = 1'b0; i_bank = 6'd7; i_clkPhi0 = 1'b1;
    @(negedge clk);
    i_clkPhi0 = 1'b0;
    stall_bad = 0;
    for (int cyc = 1; cyc < TO; cyc++) begin
      @(negedge clk);
      if (!o_cs || o_rdy || o_timeout) stall_bad++;
    end
    chk("timeout_hold", stall_bad, 0);
    @(negedge clk);
    chk("timeout_flags", {29'h0, o_cs, o_timeout, o_rdy}, {29'h0, 3'b011});
    chk("timeout_di", {24'h0, o_cpuDI}, 32'hFF);
    $display("txn %0d: timeout read addr=BEEF di=%h timeout=%0b", txn_no, o_cpuDI, o_timeout);
    txn_no++;
    m_di = 8'hFF; m_valid = 1'b0;

    txn(1'b0, 16'h2000, 6'd4, 8'h00, 1, 1, 8'h5A, 1'b0, 8'h5A);
    chk("timeout_sticky", {31'h0, o_timeout}, 32'h1);

    // Reset while waiting on the controller.
    @(negedge clk);
    i_cpuAddr = 16'h4444; i_cpuWE = 1'b0; i_bank = 6'd5; i_clkPhi0 = 1'b1;
    @(negedge clk);
    i_clkPhi0 = 1'b0; i_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midwait_reset");
    reset = 1'b0; i_busy = 1'b0;
    $display("txn %0d: reset during wait addr=4444", txn_no);
    txn_no++;
    m_di = 8'h00; m_valid = 1'b0;
    txn(1'b0, 16'h4444, 6'd5, 8'h00, 2, 2, 8'h99, 1'b0, 8'h99);

`ifdef CPU_READ_CACHE_EN
    txn(1'b0, 16'hC000, 6'd0, 8'h00, 1, 2, 8'h79, 1'b0, 8'h79);
    txn(1'b0, 16'hC000, 6'd0, 8'h00, 1, 2, 8'h11, 1'b0, 8'h79);
    txn(1'b1, 16'hC000, 6'd0, 8'h42, 1, 2, 8'h00, 1'b0, 8'h42);
    txn(1'b0, 16'hC000, 6'd0, 8'h00, 1, 2, 8'h22, 1'b0, 8'h42);
`endif

    // Randomized accesses against the model.
    for (int i = 0; i < 40; i++) begin
      we_r = 1'($urandom_range(0, 1));
      a_r  = addr_pool[$urandom_range(0, 3)];
      b_r  = 6'($urandom_range(0, 1));
      w_r  = 8'($urandom_range(0, 255));
      r_r  = 8'($urandom_range(0, 255));
      bd   = $urandom_range(0, 3);
      rd   = we_r ? $urandom_range(1, 4) : $urandom_range(0, 4);
      dr   = (bd + rd >= 3) && ($urandom_range(0, 3) == 0);
      txn(we_r, a_r, b_r, w_r, bd, rd, r_r, dr, predict(we_r, b_r, a_r, w_r, r_r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
